addition_subtraction: RTL and testbench
=======================================

ADDITION_SUBTRACTION -- requirements
Module: addition_subtraction

Interface
REQ-001 Parameters: none; all widths fixed at IEEE-754 single precision (32 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 a_operand  input  32  IEEE-754 single operand A.
REQ-005 b_operand  input  32  IEEE-754 single operand B.
REQ-006 AddBar_Sub  input  1  0 = A+B, 1 = A-B.
REQ-007 result  output  32  registered IEEE-754 sum/difference.
REQ-008 Exception  output  1  registered flag: invalid operand or overflow.
REQ-009 greater  output  1  registered flag: A > B numerically, independent of AddBar_Sub.

Function
REQ-010 Inputs sampled every rising clk edge when reset=0; outputs reflect those inputs exactly 1 cycle later; no handshake, new operation accepted every cycle.
REQ-011 Subtraction: invert B sign bit, then perform addition.
REQ-012 Operand decode: exponent 0 (zero or denormal) treated as signed zero (flush-to-zero); otherwise mantissa = {1'b1, frac[22:0]}.
REQ-013 Alignment: smaller-magnitude operand right-shifted by exponent difference; difference >= 25 leaves larger operand unchanged.
REQ-014 Same effective sign: add mantissas; carry-out -> shift right 1, exponent +1.
REQ-015 Opposite signs: subtract smaller magnitude from larger; result sign = sign of larger magnitude; normalize by left shift with leading-one detection, decrementing exponent.
REQ-016 Rounding: truncation (round toward zero); discarded bits dropped, no guard/sticky.
REQ-017 Exact cancellation or both operands zero: result = 32'h00000000 (+0), Exception=0.
REQ-018 Underflow (normalized exponent would be <= 0): result = signed zero, Exception=0.
REQ-019 Overflow (exponent >= 255): result = signed infinity (exp 8'hFF, frac 0), Exception=1.
REQ-020 Either operand with exponent 8'hFF (Inf/NaN): Exception=1, result = 32'h00000000.
REQ-021 greater: 1 iff A > B by real value; sign-magnitude comparison (A positive/B negative -> 1; both positive -> larger {exp,frac} wins; both negative -> smaller {exp,frac} wins).
REQ-022 greater: +0 and -0 compare equal (greater=0); equal values -> 0; any NaN operand -> 0; flushed denormals compare as zero.
REQ-023 All outputs registered; no combinational path input->output.

Reset
REQ-024 reset=1 at rising edge: result=32'h00000000, Exception=0, greater=0 on the following cycle.
REQ-025 reset asserted mid-stream discards the operation sampled on that edge; first valid output appears 1 cycle after the first edge with reset=0.
REQ-026 Reset has priority over all operand inputs.

Verification
REQ-027 A=3F800000 (1.0), B=40000000 (2.0), AddBar_Sub=0 -> result=40400000 (3.0), Exception=0, greater=0, one cycle later.
REQ-028 A=40400000 (3.0), B=3F800000 (1.0), AddBar_Sub=1 -> result=40000000 (2.0), greater=1.
REQ-029 A=3FC00000 (1.5), B=BFC00000 (-1.5), AddBar_Sub=0 -> result=00000000, Exception=0, greater=1.
REQ-030 A=BF800000 (-1.0), B=C0000000 (-2.0), AddBar_Sub=0 -> result=C0400000 (-3.0), greater=1; A=80000000, B=00000000 -> greater=0.
REQ-031 A=7F800000 (+Inf), B=3F800000 -> Exception=1, result=00000000; A=7F7FFFFF, B=7F7FFFFF, add -> Exception=1, result=7F800000.
REQ-032 Back-to-back operations on consecutive cycles, reset pulsed between two -> outputs zero for the reset cycle, correct results before and after, 1-cycle latency throughout.

Source files
------------

// File: rtl/addition_subtraction.sv
// Single-cycle IEEE-754 single-precision adder/subtractor.
// Timing contract: operands are sampled on every rising edge while reset is
// low and the registered result, Exception and greater flags for that
// operation appear on the next edge. There is no handshake; a new operation is
// accepted every cycle. Denormals are flushed to zero and rounding truncates.
module addition_subtraction (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic [31:0] result,
    output logic        Exception,
    output logic        greater
);

    // Operand decode (subtraction flips B's sign, denormals become zero)
    logic        w_sign_a;
    logic        w_sign_b;
    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic [23:0] w_man_a;
    logic [23:0] w_man_b;
    logic        w_special;

    assign w_sign_a  = a_operand[31];
    assign w_sign_b  = b_operand[31] ^ AddBar_Sub;
    assign w_exp_a   = a_operand[30:23];
    assign w_exp_b   = b_operand[30:23];
    assign w_man_a   = (w_exp_a == 8'd0) ? 24'd0 : {1'b1, a_operand[22:0]};
    assign w_man_b   = (w_exp_b == 8'd0) ? 24'd0 : {1'b1, b_operand[22:0]};
    assign w_special = (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);

    // Order operands by magnitude; the larger one fixes sign and exponent
    logic        w_a_larger;
    logic        w_sign_l;
    logic [7:0]  w_exp_l;
    logic [7:0]  w_exp_s;
    logic [23:0] w_man_l;
    logic [23:0] w_man_s;
    logic [7:0]  w_exp_diff;
    logic [23:0] w_man_s_al;

    assign w_a_larger = {w_exp_a, w_man_a} >= {w_exp_b, w_man_b};
    assign w_sign_l   = w_a_larger ? w_sign_a : w_sign_b;
    assign w_exp_l    = w_a_larger ? w_exp_a  : w_exp_b;
    assign w_exp_s    = w_a_larger ? w_exp_b  : w_exp_a;
    assign w_man_l    = w_a_larger ? w_man_a  : w_man_b;
    assign w_man_s    = w_a_larger ? w_man_b  : w_man_a;
    assign w_exp_diff = w_exp_l - w_exp_s;
    // Bits shifted out are simply lost: this is where truncation happens
    assign w_man_s_al = (w_exp_diff >= 8'd25) ? 24'd0 : (w_man_s >> w_exp_diff);

    // Mantissa add (with carry) and subtract (never negative after ordering)
    logic [24:0] w_sum;
    logic [23:0] w_dif;
    logic [4:0]  w_lz;
    logic [22:0] w_norm_frac;

    assign w_sum = {1'b0, w_man_l} + {1'b0, w_man_s_al};
    assign w_dif = w_man_l - w_man_s_al;

    // Leading-zero count of the difference; highest set bit wins
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (w_dif[i]) w_lz = 5'(23 - i);
        end
    end

    assign w_norm_frac = 23'(w_dif << w_lz);

    // Result assembly: specials, zero, overflow, underflow, normal cases
    logic [31:0]       w_result;
    logic              w_exception;
    logic [9:0]        w_exp_add;
    logic signed [9:0] w_exp_sub;

    assign w_exp_add = {2'b00, w_exp_l} + {9'd0, w_sum[24]};
    assign w_exp_sub = $signed({2'b00, w_exp_l}) - $signed({5'd0, w_lz});

    always_comb begin
        w_result    = 32'h0000_0000;
        w_exception = 1'b0;
        if (w_special) begin
            w_exception = 1'b1;
        end else if (w_sign_a == w_sign_b) begin
            if (w_sum == 25'd0) begin
                w_result = 32'h0000_0000;
            end else if (w_exp_add >= 10'd255) begin
                w_result    = {w_sign_l, 8'hFF, 23'd0};
                w_exception = 1'b1;
            end else if (w_sum[24]) begin
                w_result = {w_sign_l, w_exp_add[7:0], w_sum[23:1]};
            end else begin
                w_result = {w_sign_l, w_exp_add[7:0], w_sum[22:0]};
            end
        end else begin
            if (w_dif == 24'd0) begin
                w_result = 32'h0000_0000;
            end else if (w_exp_sub <= 10'sd0) begin
                w_result = {w_sign_l, 31'd0};
            end else begin
                w_result = {w_sign_l, w_exp_sub[7:0], w_norm_frac};
            end
        end
    end

    // Real-value comparison of the raw operands (AddBar_Sub is ignored)
    logic        w_greater;
    logic        w_nan;
    logic [30:0] w_mag_a;
    logic [30:0] w_mag_b;

    assign w_nan   = ((w_exp_a == 8'hFF) && (a_operand[22:0] != 23'd0)) ||
                     ((w_exp_b == 8'hFF) && (b_operand[22:0] != 23'd0));
    assign w_mag_a = (w_exp_a == 8'd0) ? 31'd0 : a_operand[30:0];
    assign w_mag_b = (w_exp_b == 8'd0) ? 31'd0 : b_operand[30:0];

    // Sign-magnitude compare; both zeros compare equal whatever their signs
    always_comb begin
        w_greater = 1'b0;
        if (w_nan || ((w_mag_a == 31'd0) && (w_mag_b == 31'd0))) begin
            w_greater = 1'b0;
        end else begin
            case ({a_operand[31], b_operand[31]})
                2'b01:   w_greater = 1'b1;
                2'b10:   w_greater = 1'b0;
                2'b00:   w_greater = w_mag_a > w_mag_b;
                default: w_greater = w_mag_a < w_mag_b;
            endcase
        end
    end

    // Output registers; reset overrides whatever operands are present
    logic [31:0] r_result;
    logic        r_exception;
    logic        r_greater;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= 32'h0000_0000;
            r_exception <= 1'b0;
            r_greater   <= 1'b0;
        end else begin
            r_result    <= w_result;
            r_exception <= w_exception;
            r_greater   <= w_greater;
        end
    end

    assign result    = r_result;
    assign Exception = r_exception;
    assign greater   = r_greater;

endmodule

// File: tb/tb_addition_subtraction.sv
// Bench for addition_subtraction: directed table, reset sequences and
// randomized operands checked against a behavioural reference model.
module tb_addition_subtraction;

    logic        clk;
    logic        reset;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        AddBar_Sub;
    logic [31:0] result;
    logic        Exception;
    logic        greater;

    int n_vec;
    int n_err;

    // {result, Exception, greater}
    logic [33:0] exp_q[$];

    addition_subtraction dut (
        .clk        (clk),
        .reset      (reset),
        .a_operand  (a_operand),
        .b_operand  (b_operand),
        .AddBar_Sub (AddBar_Sub),
        .result     (result),
        .Exception  (Exception),
        .greater    (greater)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        exc;
        logic        gt;
    } vec_t;

    vec_t vecs[16];

    // Reference model: value-level arithmetic on (sign, exponent, significand)
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic sub, output logic [31:0] res,
                                      output logic exc, output logic gt);
        longint ea, eb, ma, mb, el, es, ml, ms, m, e, va, vb;
        bit     sa, sb, sl;
        ea = longint'(a[30:23]);
        eb = longint'(b[30:23]);
        ma = (ea == 0) ? 0 : ((longint'(1) << 23) + longint'(a[22:0]));
        mb = (eb == 0) ? 0 : ((longint'(1) << 23) + longint'(b[22:0]));
        sa = a[31];
        sb = b[31] ^ sub;

        // greater: compare real values, NaN never greater
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
            gt = 1'b0;
        end else begin
            va = (ea == 0) ? 0 : longint'(a[30:0]);
            vb = (eb == 0) ? 0 : longint'(b[30:0]);
            if (a[31]) va = -va;
            if (b[31]) vb = -vb;
            gt = (va > vb);
        end

        res = 32'h0;
        exc = 1'b0;
        if (ea == 255 || eb == 255) begin
            exc = 1'b1;
            return;
        end
        if (ea * 33554432 + ma >= eb * 33554432 + mb) begin
            el = ea; ml = ma; es = eb; ms = mb; sl = sa;
        end else begin
            el = eb; ml = mb; es = ea; ms = ma; sl = sb;
        end
        if (el - es >= 25) ms = 0;
        else ms = ms >> (el - es);
        e = el;
        if (sa == sb) begin
            m = ml + ms;
            if (m == 0) return;
            while (m >= (longint'(1) << 24)) begin
                m = m / 2;
                e = e + 1;
            end
            if (e >= 255) begin
                res = {sl, 8'hFF, 23'd0};
                exc = 1'b1;
                return;
            end
        end else begin
            m = ml - ms;
            if (m == 0) return;
            while (m < (longint'(1) << 23)) begin
                m = m * 2;
                e = e - 1;
            end
            if (e <= 0) begin
                res = {sl, 31'd0};
                return;
            end
        end
        res = {sl, e[7:0], m[22:0]};
    endfunction

    // Drive one operation, then compare the registered outputs one edge later
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic rst, input logic [33:0] expv, input string name);
        logic [33:0] want;
        logic [33:0] got;
        reset      = rst;
        a_operand  = a;
        b_operand  = b;
        AddBar_Sub = sub;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        got  = {result, Exception, greater};
        want = exp_q.pop_front();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s a=%h b=%h sub=%b rst=%b: got res=%h exc=%b gt=%b, want res=%h exc=%b gt=%b",
                     name, a, b, sub, rst, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
        end
        @(negedge clk);
    endtask

    task automatic step_model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input string name);
        logic [31:0] r;
        logic        x;
        logic        g;
        ref_model(a, b, sub, r, x, g);
        step(a, b, sub, 1'b0, {r, x, g}, name);
    endtask

    function automatic logic [31:0] rand_operand(input logic [31:0] other);
        int          mode;
        int          e;
        logic [31:0] v;
        mode = $urandom_range(0, 5);
        v    = $urandom;
        case (mode)
            0, 1: begin
                e = int'(other[30:23]) + $urandom_range(0, 30) - 15;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                v[30:23] = 8'(e);
            end
            2: v[30:23] = other[30:23];
            3: v[30:23] = 8'($urandom_range(0, 3));
            4: if ($urandom_range(0, 3) == 0) v[30:23] = 8'hFF;
            default: ;
        endcase
        if ($urandom_range(0, 15) == 0) v = other;
        if ($urandom_range(0, 15) == 0) v = {~other[31], other[30:0]};
        return v;
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        a_operand  = 32'h0;
        b_operand  = 32'h0;
        AddBar_Sub = 1'b0;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b1};
        vecs[2]  = '{32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[3]  = '{32'hBF800000, 32'hC0000000, 1'b0, 32'hC0400000, 1'b0, 1'b1};
        vecs[4]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[7]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
        vecs[9]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[10] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b0, 1'b0};
        vecs[11] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b1};
        vecs[12] = '{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 1'b0, 1'b1};
        vecs[13] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 1'b0, 1'b1};
        vecs[14] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[15] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1, 1'b0};

        // Reset state, with non-zero operands present to show reset priority
        @(negedge clk);
        step(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 34'h0, "reset_0");
        step(32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 34'h0, "reset_1");

        // Directed table
        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0,
                 {vecs[i].res, vecs[i].exc, vecs[i].gt}, $sformatf("table_%0d", i));
        end

        // Back-to-back with a reset pulse in the middle
        step(32'h3F800000, 32'h40000000, 1'b0, 1'b0, {32'h40400000, 1'b0, 1'b0}, "b2b_before");
        step(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 34'h0, "b2b_reset");
        step(32'h40400000, 32'h3F800000, 1'b1, 1'b0, {32'h40000000, 1'b0, 1'b1}, "b2b_after");
        step(32'hBF800000, 32'hC0000000, 1'b0, 1'b0, {32'hC0400000, 1'b0, 1'b1}, "b2b_next");

        // Randomized operands against the model
        for (int k = 0; k < 800; k++) begin
            ra = $urandom;
            rb = rand_operand(ra);
            if ($urandom_range(0, 1) == 1) begin
                ra = rb;
                rb = rand_operand(ra);
            end
            if ($urandom_range(0, 49) == 0) begin
                step(ra, rb, 1'($urandom_range(0, 1)), 1'b1, 34'h0, "rand_reset");
            end else begin
                step_model(ra, rb, 1'($urandom_range(0, 1)), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
